// File: rtl/beta_imem_responder.sv
// ----------------------------------------------------------------------------
// beta_imem_responder
//   Instruction-memory responder for a fetch unit. Accepts one fetch at a
//   time, waits WaitStates cycles, then returns the addressed word as a
//   single-cycle valid pulse. A side port loads the program one word per
//   cycle and never stalls a fetch.
//
// Ports
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   instr_req_i         fetch request
//   instr_addr_i        fetch byte address
//   instr_ready_o       a request is accepted this cycle if instr_req_i=1
//   instr_valid_o       one-cycle response pulse
//   instr_rdata_o       response word (0 on error), held between pulses
//   instr_err_o         response flags a misaligned / out-of-range address
//   prog_we_i           program-load write enable
//   prog_addr_i         program-load byte address
//   prog_wdata_i        program-load data
// ----------------------------------------------------------------------------
module beta_imem_responder #(
    parameter int DataWidth  = 32,
    parameter int MemDepth   = 1024,
    parameter int WaitStates = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 instr_req_i,
    input  logic [DataWidth-1:0] instr_addr_i,
    output logic                 instr_ready_o,
    output logic                 instr_valid_o,
    output logic [DataWidth-1:0] instr_rdata_o,
    output logic                 instr_err_o,
    input  logic                 prog_we_i,
    input  logic [DataWidth-1:0] prog_addr_i,
    input  logic [DataWidth-1:0] prog_wdata_i
);

    localparam int         AW       = $clog2(MemDepth);
    localparam logic [3:0] WaitLoad = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    typedef enum logic [1:0] {BOOT, IDLE, WAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DataWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    // Program memory; deliberately not reset so a reset keeps the program.
    logic [DataWidth-1:0] mem_q [MemDepth];

    function automatic logic addr_bad(input logic [DataWidth-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DataWidth'(MemDepth));
    endfunction

    logic                 accept;
    logic                 go_resp;
    logic [DataWidth-1:0] rd_addr;
    logic                 rd_bad;
    logic [AW-1:0]        rd_idx;
    logic [DataWidth-1:0] rd_word;
    logic                 wr_ok;
    logic [AW-1:0]        wr_idx;

    assign instr_ready_o = (state_q == IDLE) || (state_q == RESP);
    assign instr_valid_o = (state_q == RESP);
    assign instr_rdata_o = rdata_q;
    assign instr_err_o   = err_q;
    assign accept        = instr_req_i && instr_ready_o;

    // The read happens in the cycle before RESP: from the captured address
    // while waiting, or straight from the bus when there are no wait states.
    assign rd_addr = (state_q == WAIT) ? addr_q : instr_addr_i;
    assign rd_bad  = addr_bad(rd_addr);
    assign rd_idx  = rd_addr[AW+1:2];

    assign wr_ok  = prog_we_i && (state_q != BOOT) && !addr_bad(prog_addr_i);
    assign wr_idx = prog_addr_i[AW+1:2];

    // Same-cycle write to the word being read wins, so the fetch sees it.
    assign rd_word = (wr_ok && (wr_idx == rd_idx)) ? prog_wdata_i : mem_q[rd_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        go_resp = 1'b0;
        case (state_q)
            BOOT: state_d = IDLE;
            IDLE, RESP: begin
                if (accept) begin
                    addr_d = instr_addr_i;
                    if (WaitStates > 0) begin
                        state_d = WAIT;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = BOOT;
        endcase
        if (go_resp) begin
            rdata_d = rd_bad ? '0 : rd_word;
            err_d   = rd_bad;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= BOOT;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_idx] <= prog_wdata_i;
    end

endmodule

// File: doc/beta_imem_responder.md
BETA_IMEM_RESPONDER -- requirements
Module: beta_imem_responder

Interface
REQ-001 Parameters SHALL be: DataWidth, default 32, data/address width; MemDepth, default 1024, number of DataWidth words; WaitStates, default 1, extra cycles between accept and response, legal range 0..15.
REQ-002 clk_i  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rstn_i  in  1  asynchronous active-low reset.
REQ-004 instr_req_i  in  1  fetch request from the fetch unit.
REQ-005 instr_addr_i  in  DataWidth  byte address of the requested instruction.
REQ-006 instr_ready_o  out  1  responder can accept a request this cycle.
REQ-007 instr_valid_o  out  1  single-cycle pulse; instr_rdata_o holds the response.
REQ-008 instr_rdata_o  out  DataWidth  instruction word returned.
REQ-009 instr_err_o  out  1  pulses with instr_valid_o when the accepted address was misaligned or out of range.
REQ-010 prog_we_i  in  1  program-load write enable.
REQ-011 prog_addr_i  in  DataWidth  byte address for the program-load write.
REQ-012 prog_wdata_i  in  DataWidth  program-load write data.

Function
REQ-013 A request SHALL be accepted in any cycle where instr_req_i and instr_ready_o are both 1; instr_addr_i SHALL be captured in that cycle.
REQ-014 The FSM SHALL have states BOOT, IDLE, WAIT and RESP.
REQ-015 BOOT SHALL go to IDLE unconditionally after one cycle; instr_ready_o SHALL be 0 in BOOT.
REQ-016 In IDLE, instr_ready_o SHALL be 1. On acceptance the FSM SHALL go to WAIT if WaitStates>0, otherwise to RESP; with no acceptance it SHALL stay in IDLE.
REQ-017 In WAIT, instr_ready_o SHALL be 0. A 4-bit down-counter loaded with WaitStates-1 on acceptance SHALL decrement each cycle; at zero the FSM SHALL go to RESP.
REQ-018 In RESP, instr_valid_o SHALL be 1 for exactly one cycle and instr_ready_o SHALL be 1.
  - A request accepted in RESP SHALL follow the IDLE transitions (back-to-back).
  - Otherwise the FSM SHALL go to IDLE.
REQ-019 Latency: a request accepted in cycle N SHALL produce instr_valid_o in cycle N+1+WaitStates.
REQ-020 Word index SHALL be addr[log2(MemDepth)+1:2].
  - Misaligned means addr[1:0]!=0.
  - Out of range means addr >= 4*MemDepth.
  - In either case instr_rdata_o SHALL be 0 and instr_err_o SHALL be 1 in the RESP cycle.
REQ-021 The memory read SHALL be performed in the cycle before RESP. A prog_we_i write to the same word in that cycle SHALL be bypassed, so that the new data is returned.
REQ-022 A program write SHALL complete in one cycle at any time, in any state except BOOT.
  - A misaligned or out-of-range write SHALL be ignored.
  - A write SHALL never stall a fetch.
REQ-023 instr_rdata_o and instr_err_o SHALL hold their last values when instr_valid_o is 0.
REQ-024 instr_req_i deasserted after acceptance SHALL NOT cancel the in-flight response.

Reset
REQ-025 While rstn_i is 0 the block SHALL be held in reset:
  - state = BOOT;
  - instr_ready_o = 0, instr_valid_o = 0, instr_err_o = 0, instr_rdata_o = 0;
  - counter = 0.
REQ-026 Reset asserted mid-transaction SHALL drop the outstanding response; no instr_valid_o SHALL appear after reset release until a new request is accepted.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-028 Reset release, instr_req_i=1 held -> instr_ready_o=0 for the first cycle (BOOT), 1 from the second cycle; first accept in the second cycle.
REQ-029 WaitStates=1; preload word 3 = 0x00A00093; request addr 0x0C accepted in cycle N -> instr_valid_o=1 in cycle N+2, rdata=0x00A00093, err=0, ready=0 in cycle N+1.
REQ-030 WaitStates=0; requests held for addrs 0x0, 0x4, 0x8 -> valid pulses on three consecutive cycles with matching words, ready=1 throughout.
REQ-031 Request addr 0x6 and, with MemDepth=1024, addr 0x1000 -> valid=1, err=1, rdata=0x00000000 for each; no error on the following good request.
REQ-032 WaitStates=2; request word 5; prog_we_i writes 0xDEADBEEF to addr 0x14 in the cycle before RESP -> rdata=0xDEADBEEF.
REQ-033 rstn_i pulsed low during WAIT -> no instr_valid_o afterwards; the BOOT cycle is repeated; memory contents are preserved on the next read.
